ex_stage: RTL
=============

# ex_stage

Execute stage of the 5-stage MIPS pipeline, sitting directly downstream of the ID/EX pipeline register and feeding the EX/MEM register. It applies operand forwarding, performs ALU operations, resolves branches, computes the write-back register, and passes memory/write-back controls through. It also contains an iterative multiply/divide unit with architectural HI/LO registers, which stalls the front of the pipeline while busy.

## Interface
- Parameters: none. Datapath is fixed at 32 bits; MD iteration count is fixed at 32.
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears FSM, counter, HI, LO
- PCplus4, readData1, readData2, imm  in  32 each  from ID/EX; imm is sign-extended, shamt = imm[10:6]
- rs, rt, rd  in  5 each  register fields from ID/EX
- funct  in  6  R-type function field
- RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, Branch, Jump  in  1 each  control from ID/EX
- ALUOp  in  2  00 add, 01 sub, 10 decode funct, 11 add
- ForwardA, ForwardB  in  2 each  00 register file, 10 EX/MEM, 01 MEM/WB, 11 register file
- exmem_aluResult, memwb_writeData  in  32 each  forwarding sources
- aluResult  out  32  ALU or mfhi/mflo result
- writeData  out  32  forwarded rt operand (store data)
- writeReg  out  5  RegDst ? rd : rt
- zero  out  1  ALU result == 0
- branchTaken  out  1  Branch & zero
- branchTarget  out  32  PCplus4 + (imm << 2), modulo 2^32
- MemRead_out, MemWrite_out, MemtoReg_out, RegWrite_out, Jump_out  out  1 each  combinational pass-through
- md_stall  out  1  stall PC, IF/ID and ID/EX; EX/MEM must load a bubble while high

## Operation
- Operand A = forward mux on readData1; forwarded B = forward mux on readData2 (drives writeData); ALU B = ALUSrc ? imm : forwarded B.
- R-type funct (ALUOp 10): 20/21 add, 22/23 sub, 24 and, 25 or, 26 xor, 27 nor, 2A slt (signed), 2B sltu, 00 sll, 02 srl, 03 sra (shift B by shamt), 10 mfhi, 12 mflo, any other code → add. No overflow traps; wrap mod 2^32.
- MD ops (ALUOp 10): 18 mult, 19 multu, 1A div, 1B divu. Issue = MD funct present & state IDLE.
- FSM states:
  - IDLE: on issue, latch A and B and op, counter ← 0, go to BUSY.
  - BUSY: one shift-add (mult) or restoring-divide step per cycle on magnitudes; counter increments; after step 31, write HI/LO and go to DONE.
  - DONE: issue is masked for one cycle so the held instruction cannot restart; then go to IDLE.
- md_stall = issue (combinational, in IDLE) | state==BUSY. Low in DONE and IDLE otherwise.
- Signed mult: 64-bit product of magnitudes, negated if the signs differ; HI = [63:32], LO = [31:0].
- Signed div: LO = quotient, negated if the signs differ; HI = remainder, carrying the dividend's sign. 0x80000000 / −1 → LO=0x80000000, HI=0.
- Divide by zero, signed or unsigned: LO=0xFFFFFFFF, HI=dividend; the full latency still applies.
- MD instructions do not modify aluResult semantics; they pass RegWrite through unchanged (the decoder drives 0).

## Timing
- All non-MD outputs are combinational from the current inputs; zero cycles of latency.
- MD op entering EX in cycle 0: md_stall=1 in cycles 0–32; HI/LO update at the edge ending cycle 32; DONE in cycle 33 (md_stall=0); the instruction leaves EX at the end of cycle 33; IDLE from cycle 34.
- mfhi/mflo in the instruction directly after an MD op sees the new HI/LO; no extra hazard.
- Back-to-back MD ops: the second issues in cycle 34, with no overlap.
- reset high at any edge, including mid-BUSY: state=IDLE, counter=0, HI=LO=0, and md_stall=0 in the next cycle. The operation is abandoned without a HI/LO write.
- Reset values: HI=0, LO=0, md_stall=0. With ID/EX held at zero after reset: aluResult=0, zero=1, branchTaken=0, writeReg=0.

## Test plan
- Forwarding: readData1=5, exmem_aluResult=7, ForwardA=10, add with B=3 → aluResult=10; with ForwardA=01 and memwb_writeData=1 → aluResult=4.
- Branch: ALUOp=01, Branch=1, A=B=0x1234, PCplus4=0x100, imm=0xFFFFFFFE → zero=1, branchTaken=1, branchTarget=0xF8.
- mult: A=0xFFFFFFFE (−2), B=3 → md_stall high for exactly 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA. Following mflo → aluResult=0xFFFFFFFA.
- div: 
  - A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=9, B=0 → LO=0xFFFFFFFF, HI=9.
- Reset mid-op: assert reset at BUSY cycle 10 of multu 0xFFFFFFFF×0xFFFFFFFF → next cycle md_stall=0, HI=LO=0. A fresh multu then gives HI=0xFFFFFFFE, LO=1.
- Shifts and set-less-than:
  - sra shamt=4 on B=0x80000000 → 0xF8000000.
  - sltu A=1, B=0xFFFFFFFF → 1; slt on the same operands → 0.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of a 5-stage MIPS pipeline.
// Applies operand forwarding, runs the ALU, resolves branches, selects the
// write-back register and passes MEM/WB controls through. It also holds an
// iterative multiply/divide unit with architectural HI/LO registers. The unit
// stalls the front of the pipeline while it is busy.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   PCplus4 .. funct        ID/EX datapath fields (imm sign-extended, shamt = imm[10:6])
//   RegDst .. Jump, ALUOp   ID/EX control
//   ForwardA/B              forward select: 10 EX/MEM, 01 MEM/WB, else register file
//   exmem_aluResult,
//   memwb_writeData         forwarding sources
//   aluResult, writeData,
//   writeReg, zero,
//   branchTaken,
//   branchTarget            execute results (combinational)
//   *_out                   control pass-through
//   md_stall                hold PC/IF/ID/ID/EX and bubble EX/MEM while high
`timescale 1ns/1ps
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCplus4,
    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
    input  logic [31:0] imm,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic        RegDst,
    input  logic        ALUSrc,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic        Branch,
    input  logic        Jump,
    input  logic [1:0]  ALUOp,
    input  logic [1:0]  ForwardA,
    input  logic [1:0]  ForwardB,
    input  logic [31:0] exmem_aluResult,
    input  logic [31:0] memwb_writeData,
    output logic [31:0] aluResult,
    output logic [31:0] writeData,
    output logic [4:0]  writeReg,
    output logic        zero,
    output logic        branchTaken,
    output logic [31:0] branchTarget,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        MemtoReg_out,
    output logic        RegWrite_out,
    output logic        Jump_out,
    output logic        md_stall
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

    md_state_e   state_q;
    logic [4:0]  count_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] work_hi_q, work_lo_q;  // remainder/quotient or product halves
    logic [31:0] opnd_q;                // multiplicand or divisor magnitude
    logic [31:0] dividend_q;            // raw dividend, returned in HI on divide by zero
    logic        is_div_q, neg_lo_q, neg_hi_q, div_zero_q;

    logic [31:0] op_a, fwd_b, alu_b;
    logic [4:0]  shamt;
    logic [31:0] alu_res;

    logic        md_funct, issue, md_signed, md_div;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum, div_shift, div_diff;
    logic [31:0] step_hi, step_lo;
    logic [63:0] prod, prod_neg;
    logic [31:0] fin_hi, fin_lo;

    logic unused_rs;
    assign unused_rs = ^rs;

    // Operand forwarding
    always_comb begin
        unique case (ForwardA)
            2'b10:   op_a = exmem_aluResult;
            2'b01:   op_a = memwb_writeData;
            default: op_a = readData1;
        endcase
        unique case (ForwardB)
            2'b10:   fwd_b = exmem_aluResult;
            2'b01:   fwd_b = memwb_writeData;
            default: fwd_b = readData2;
        endcase
    end

    assign alu_b     = ALUSrc ? imm : fwd_b;
    assign writeData = fwd_b;
    assign shamt     = imm[10:6];

    always_comb begin
        alu_res = op_a + alu_b;
        if (ALUOp == 2'b01) begin
            alu_res = op_a - alu_b;
        end else if (ALUOp == 2'b10) begin
            case (funct)
                6'h22, 6'h23: alu_res = op_a - alu_b;
                6'h24:        alu_res = op_a & alu_b;
                6'h25:        alu_res = op_a | alu_b;
                6'h26:        alu_res = op_a ^ alu_b;
                6'h27:        alu_res = ~(op_a | alu_b);
                6'h2A:        alu_res = {31'd0, $signed(op_a) < $signed(alu_b)};
                6'h2B:        alu_res = {31'd0, op_a < alu_b};
                6'h00:        alu_res = alu_b << shamt;
                6'h02:        alu_res = alu_b >> shamt;
                6'h03:        alu_res = $signed(alu_b) >>> shamt;
                6'h10:        alu_res = hi_q;
                6'h12:        alu_res = lo_q;
                default:      alu_res = op_a + alu_b;
            endcase
        end
    end

    assign aluResult    = alu_res;
    assign zero         = (alu_res == 32'd0);
    assign branchTaken  = Branch & zero;
    assign branchTarget = PCplus4 + {imm[29:0], 2'b00};
    assign writeReg     = RegDst ? rd : rt;

    assign MemRead_out  = MemRead;
    assign MemWrite_out = MemWrite;
    assign MemtoReg_out = MemtoReg;
    assign RegWrite_out = RegWrite;
    assign Jump_out     = Jump;

    // Multiply/divide issue; DONE masks issue so the held instruction cannot restart
    assign md_funct  = (ALUOp == 2'b10) && (funct[5:2] == 4'b0110);
    assign issue     = md_funct && (state_q == StIdle);
    assign md_stall  = issue || (state_q == StBusy);
    assign md_signed = ~funct[0];
    assign md_div    = funct[1];
    assign mag_a     = (md_signed && op_a[31]) ? -op_a : op_a;
    assign mag_b     = (md_signed && fwd_b[31]) ? -fwd_b : fwd_b;

    // One shift-add or restoring-divide step on the working registers
    always_comb begin
        mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_shift = {work_hi_q, work_lo_q[31]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (is_div_q) begin
            if (!div_diff[32]) begin
                step_hi = div_diff[31:0];
                step_lo = {work_lo_q[30:0], 1'b1};
            end else begin
                step_hi = div_shift[31:0];
                step_lo = {work_lo_q[30:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], work_lo_q[31:1]};
        end
    end

    // Sign fix-up applied after the last step
    always_comb begin
        prod     = {step_hi, step_lo};
        prod_neg = -prod;
        if (!is_div_q) begin
            fin_hi = neg_lo_q ? prod_neg[63:32] : prod[63:32];
            fin_lo = neg_lo_q ? prod_neg[31:0]  : prod[31:0];
        end else if (div_zero_q) begin
            fin_hi = dividend_q;
            fin_lo = 32'hFFFF_FFFF;
        end else begin
            fin_hi = neg_hi_q ? -step_hi : step_hi;
            fin_lo = neg_lo_q ? -step_lo : step_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= 5'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            work_hi_q  <= 32'd0;
            work_lo_q  <= 32'd0;
            opnd_q     <= 32'd0;
            dividend_q <= 32'd0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (issue) begin
                        state_q    <= StBusy;
                        count_q    <= 5'd0;
                        work_hi_q  <= 32'd0;
                        work_lo_q  <= md_div ? mag_a : mag_b;
                        opnd_q     <= md_div ? mag_b : mag_a;
                        dividend_q <= op_a;
                        is_div_q   <= md_div;
                        neg_lo_q   <= md_signed && (op_a[31] ^ fwd_b[31]);
                        neg_hi_q   <= md_signed && op_a[31];
                        div_zero_q <= (fwd_b == 32'd0);
                    end
                end
                StBusy: begin
                    work_hi_q <= step_hi;
                    work_lo_q <= step_lo;
                    count_q   <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        hi_q    <= fin_hi;
                        lo_q    <= fin_lo;
                        state_q <= StDone;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
